// File: rtl/aes_pkg.sv
// Shared AES definitions used by the encryptor and the receive-side decryptor:
// S-box table, GF(2^8) helpers, key-schedule helpers, FSM state encodings.
package aes_pkg;

  localparam int AES128_NR   = 10;
  localparam int ROUND_KEY_W = 128;
  localparam int KEY_SCHED_W = (AES128_NR + 1) * ROUND_KEY_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUNDS = 2'd1,
    DONE   = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x (i.e. by 2) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for key-schedule step i (1..10).
  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r;
    case (i)
      1:       r = 8'h01;
      2:       r = 8'h02;
      3:       r = 8'h04;
      4:       r = 8'h08;
      5:       r = 8'h10;
      6:       r = 8'h20;
      7:       r = 8'h40;
      8:       r = 8'h80;
      9:       r = 8'h1b;
      10:      r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped on the last round) and AddRoundKey. Byte 0 is at [127:120],
// bytes are column-major (byte index = row + 4*col).
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  logic [7:0] a0, a1, a2, a3;

  // SubBytes on every byte.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_in[127-8*i -: 8]);
    end
  end

  // ShiftRows: row r rotates left by r columns.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
  end

  // MixColumns on each column.
  always_comb begin
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  // AddRoundKey, bypassing MixColumns on the final round.
  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// Combinational AES-128 key schedule. Round key r is w[1407 - r*128 -: 128],
// so the original key sits at the MSB end.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic [ROUND_KEY_W-1:0] key,
  output logic [KEY_SCHED_W-1:0] w
);

  logic [31:0] words [4*(AES128_NR+1)];
  logic [31:0] temp;

  // Expand the 4 key words into 44 schedule words.
  always_comb begin
    temp = '0;
    for (int i = 0; i < 4; i++) begin
      words[i] = key[127-32*i -: 32];
    end
    for (int i = 4; i < 4*(AES128_NR+1); i++) begin
      temp = words[i-1];
      if (i % 4 == 0) begin
        temp = sub_word(rot_word(temp)) ^ {rcon(i/4), 24'h000000};
      end
      words[i] = words[i-4] ^ temp;
    end
  end

  // Pack the words MSB-first into the flat schedule bus.
  always_comb begin
    w = '0;
    for (int i = 0; i < 4*(AES128_NR+1); i++) begin
      w[KEY_SCHED_W-1-32*i -: 32] = words[i];
    end
  end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor, one round per clock, valid/ready on both sides.
// Optional macro AES_ENC_KEY_LATCH_EN: capture the key at accept so the key
// port may change while the block is in flight.
module aes_encrypt
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  input  logic         start,
  output logic         ready,
  output logic [127:0] ciphertext,
  output logic         done,
  input  logic         ser_ready
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_state_e   state, state_nxt;
  logic [3:0]   round_cnt, round_cnt_nxt;
  logic [127:0] state_reg, state_reg_nxt;
  logic [127:0] ciphertext_nxt;
  logic         ready_nxt, done_nxt;

  logic [127:0]           sched_key;
  logic [KEY_SCHED_W-1:0] w;
  logic [127:0]           round_key;
  logic [127:0]           round_out;
  logic                   last_round;
  logic                   accept;

  assign accept = (state == IDLE) && start && ready;

`ifdef AES_ENC_KEY_LATCH_EN
  logic [127:0] key_reg;

  // Hold the key captured at accept for the whole schedule.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_reg <= '0;
    end else if (accept) begin
      key_reg <= key;
    end
  end

  assign sched_key = key_reg;
`else
  assign sched_key = key;
`endif

  aes_key_expand u_key_expand (
    .key (sched_key),
    .w   (w)
  );

  // Select the round key for the current round counter.
  always_comb begin
    round_key = '0;
    for (int r = 0; r <= AES128_NR; r++) begin
      if (round_cnt == 4'(r)) begin
        round_key = w[KEY_SCHED_W-1-128*r -: 128];
      end
    end
  end

  assign last_round = (round_cnt == LAST_ROUND);

  aes_enc_round u_round (
    .state_in   (state_reg),
    .round_key  (round_key),
    .last_round (last_round),
    .state_out  (round_out)
  );

  // Register all FSM state and the registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      round_cnt  <= '0;
      state_reg  <= '0;
      ciphertext <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      round_cnt  <= round_cnt_nxt;
      state_reg  <= state_reg_nxt;
      ciphertext <= ciphertext_nxt;
      ready      <= ready_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state logic: accept, iterate rounds, hold result until taken.
  always_comb begin
    state_nxt      = state;
    round_cnt_nxt  = round_cnt;
    state_reg_nxt  = state_reg;
    ciphertext_nxt = ciphertext;
    ready_nxt      = ready;
    done_nxt       = done;
    case (state)
      IDLE: begin
        done_nxt = 1'b0;
        if (accept) begin
          // Initial AddRoundKey always uses the live key port.
          state_reg_nxt = plaintext ^ key;
          round_cnt_nxt = 4'd1;
          ready_nxt     = 1'b0;
          state_nxt     = ROUNDS;
        end else begin
          ready_nxt = 1'b1;
        end
      end
      ROUNDS: begin
        state_reg_nxt = round_out;
        if (last_round) begin
          ciphertext_nxt = round_out;
          done_nxt       = 1'b1;
          round_cnt_nxt  = '0;
          state_nxt      = DONE;
        end else begin
          round_cnt_nxt = round_cnt + 4'd1;
        end
      end
      DONE: begin
        if (ser_ready) begin
          done_nxt  = 1'b0;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        round_cnt_nxt = '0;
        ready_nxt     = 1'b1;
        done_nxt      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt: known-answer vectors from a table plus
// hand-written back-pressure, back-to-back, reset-abort and key-change cases.
module tb_aes_encrypt;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         start = 1'b0;
  logic         ready;
  logic [127:0] ciphertext;
  logic         done;
  logic         ser_ready = 1'b0;

  int vectors_applied = 0;
  int miscompares = 0;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  aes_encrypt dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .plaintext  (plaintext),
    .start      (start),
    .ready      (ready),
    .ciphertext (ciphertext),
    .done       (done),
    .ser_ready  (ser_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic checkDiffer(input string name, input logic [127:0] got, input logic [127:0] avoid);
    vectors_applied++;
    if (got === avoid) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected any value other than %h", name, got, avoid);
    end
  endtask

  // Wait for ready, present one block, return on the negedge after the accept edge.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] p);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", 128'(ready), 128'd1);
    key       = k;
    plaintext = p;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Count clock edges after the accept edge until done is seen.
  task automatic waitDone(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int gap;
    logic flag_done, flag_ct, flag_rdy;

    vecs[0] = '{"fips_c1",   C1_KEY, C1_PT, C1_CT};
    vecs[1] = '{"fips_b",    B_KEY,  B_PT,  B_CT};
    vecs[2] = '{"all_zero",  '0,     '0,    Z_CT};

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 128'(ready), 128'd1);
    checkOutput("reset_done",  128'(done),  128'd0);
    checkOutput("reset_ct",    ciphertext,  128'd0);
    reset = 1'b0;

    // Known-answer vectors with the serializer always ready.
    ser_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i].key, vecs[i].pt);
      checkOutput({vecs[i].name, "_ready_busy"}, 128'(ready), 128'd0);
      waitDone(lat);
      checkOutput({vecs[i].name, "_latency"}, 128'(lat), 128'd10);
      checkOutput({vecs[i].name, "_ct"}, ciphertext, vecs[i].ct);
      @(negedge clk);
      checkOutput({vecs[i].name, "_done_one_cycle"}, 128'(done), 128'd0);
      checkOutput({vecs[i].name, "_ready_back"}, 128'(ready), 128'd1);
    end

    // Back-pressure: hold DONE for 20 cycles, ignore a second start.
    ser_ready = 1'b0;
    applyStimulus(C1_KEY, C1_PT);
    waitDone(lat);
    checkOutput("bp_ct", ciphertext, C1_CT);
    flag_done = 1'b0;
    flag_ct   = 1'b0;
    flag_rdy  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 5) begin
        key       = B_KEY;
        plaintext = B_PT;
        start     = 1'b1;
      end
      if (c == 12) start = 1'b0;
      if (done !== 1'b1) flag_done = 1'b1;
      if (ciphertext !== C1_CT) flag_ct = 1'b1;
      if (ready !== 1'b0) flag_rdy = 1'b1;
    end
    checkOutput("bp_done_held",  128'(flag_done), 128'd0);
    checkOutput("bp_ct_stable",  128'(flag_ct),   128'd0);
    checkOutput("bp_ready_low",  128'(flag_rdy),  128'd0);
    ser_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_done",  128'(done),  128'd0);
    checkOutput("bp_release_ready", 128'(ready), 128'd1);
    checkOutput("bp_ct_retained",   ciphertext,  C1_CT);

    // Back-to-back with start held high: C.1 then B, 12 cycles apart.
    @(negedge clk);
    key       = C1_KEY;
    plaintext = C1_PT;
    start     = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    checkOutput("b2b_first_ct", ciphertext, C1_CT);
    key       = B_KEY;
    plaintext = B_PT;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done && gap < 40);
    start = 1'b0;
    checkOutput("b2b_spacing",   128'(gap), 128'd12);
    checkOutput("b2b_second_ct", ciphertext, B_CT);
    @(negedge clk);

    // Reset in the middle of the rounds aborts the block.
    applyStimulus(B_KEY, B_PT);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_done",  128'(done),  128'd0);
    checkOutput("midreset_ready", 128'(ready), 128'd1);
    checkOutput("midreset_ct",    ciphertext,  128'd0);
    @(negedge clk);
    reset = 1'b0;
    flag_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0) flag_done = 1'b1;
    end
    checkOutput("midreset_no_done", 128'(flag_done), 128'd0);
    applyStimulus(C1_KEY, C1_PT);
    waitDone(lat);
    checkOutput("after_reset_ct", ciphertext, C1_CT);
    @(negedge clk);

    // Key port changes to all-ones the cycle after accept.
    applyStimulus(C1_KEY, C1_PT);
    key = '1;
    waitDone(lat);
`ifdef AES_ENC_KEY_LATCH_EN
    checkOutput("key_change_ct", ciphertext, C1_CT);
`else
    checkDiffer("key_change_ct", ciphertext, C1_CT);
`endif
    @(negedge clk);
    key = C1_KEY;

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
